// File: rtl/plab5_mcore_mem_arbiter.sv
// plab5_mcore_mem_arbiter
//   Shares one val/rdy memory port among p_num_ports requesters. Requests are
//   granted round-robin and forwarded with zero latency; the index of every
//   granted port is queued in an in-order tracker FIFO so that memory
//   responses (which return in request order) are steered back to the port
//   that issued them. Message contents pass through untouched.
//
//   Optional feature: define PLAB5_MCORE_MEM_ARB_STATS_EN to add the
//   stall_count output, a saturating count of cycles in which at least one
//   requester was valid but no request was accepted.
module plab5_mcore_mem_arbiter #(
    parameter int p_num_ports        = 4,
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_max_outstanding  = 4,
    // Memory message widths: type(3) + opaque + addr + len + data for
    // requests, type(3) + opaque + test(2) + len + data for responses.
    localparam int rq = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                        + $clog2(p_mem_data_nbits / 8) + p_mem_data_nbits,
    localparam int rs = 3 + p_mem_opaque_nbits + 2
                        + $clog2(p_mem_data_nbits / 8) + p_mem_data_nbits
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [rq*p_num_ports-1:0] req_in_msg,
    input  logic [p_num_ports-1:0]    req_in_val,
    output logic [p_num_ports-1:0]    req_in_rdy,

    output logic [rs*p_num_ports-1:0] resp_out_msg,
    output logic [p_num_ports-1:0]    resp_out_val,
    input  logic [p_num_ports-1:0]    resp_out_rdy,

    output logic [rq-1:0]             mem_req_msg,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,

    input  logic [rs-1:0]             mem_resp_msg,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy
`ifdef PLAB5_MCORE_MEM_ARB_STATS_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    localparam int ptr_w = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
    localparam int trk_w = $clog2(p_max_outstanding);
    localparam int cnt_w = trk_w + 1;

    // Round-robin priority pointer and the combinational grant decision.
    logic [ptr_w-1:0]       rr_ptr;
    logic [p_num_ports-1:0] grant;
    logic [ptr_w-1:0]       winner;
    logic                   any_val;

    // In-order tracker of granted port indices.
    logic [ptr_w-1:0]       trk_mem [p_max_outstanding];
    logic [trk_w-1:0]       trk_wr_ptr;
    logic [trk_w-1:0]       trk_rd_ptr;
    logic [cnt_w-1:0]       trk_count;
    logic                   trk_full;
    logic                   trk_empty;
    logic [ptr_w-1:0]       head;

    logic                   req_fire;
    logic                   resp_fire;

    assign any_val   = |req_in_val;
    assign trk_full  = (trk_count == cnt_w'(p_max_outstanding));
    assign trk_empty = (trk_count == '0);
    assign head      = trk_mem[trk_rd_ptr];

    // A full tracker blocks every grant, even if a response pops this cycle.
    assign mem_req_val = any_val && !trk_full;
    assign req_fire    = mem_req_val && mem_req_rdy;
    assign resp_fire   = mem_resp_val && mem_resp_rdy;

    // Pick the first valid port at or after rr_ptr, wrapping to port 0.
    always_comb begin
        logic found;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; a missing default would infer a latch.
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < p_num_ports; i++) begin
            if (!found && req_in_val[i] && (i >= int'(rr_ptr))) begin
                grant[i] = 1'b1;
                winner   = ptr_w'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < p_num_ports; i++) begin
            if (!found && req_in_val[i]) begin
                grant[i] = 1'b1;
                winner   = ptr_w'(i);
                found    = 1'b1;
            end
        end
    end

    // Only the winner sees rdy, and only when the memory and tracker can take it.
    always_comb begin
        req_in_rdy = '0;
        if (mem_req_rdy && !trk_full)
            req_in_rdy = grant;
    end

    // Forward the winner's request message unmodified.
    always_comb begin
        mem_req_msg = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            if (grant[i])
                mem_req_msg = req_in_msg[i*rq +: rq];
        end
    end

    // Every response field carries the memory response; only the head port is valid.
    assign resp_out_msg = {p_num_ports{mem_resp_msg}};

    // Steer the response handshake to the port at the head of the tracker.
    always_comb begin
        resp_out_val = '0;
        mem_resp_rdy = 1'b0;
        if (!trk_empty) begin
            for (int i = 0; i < p_num_ports; i++) begin
                if (int'(head) == i) begin
                    resp_out_val[i] = mem_resp_val;
                    mem_resp_rdy    = resp_out_rdy[i];
                end
            end
        end
    end

    // Advance the priority pointer past the port that was just served.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (!reset)
            rr_ptr <= '0;
        else if (req_fire)
            rr_ptr <= (int'(winner) == p_num_ports - 1) ? '0 : winner + 1'b1;
    end

    // Tracker pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_wr_ptr <= '0;
            trk_rd_ptr <= '0;
            trk_count  <= '0;
        end else begin
            if (req_fire)
                trk_wr_ptr <= trk_wr_ptr + 1'b1;
            if (resp_fire)
                trk_rd_ptr <= trk_rd_ptr + 1'b1;
            case ({req_fire, resp_fire})
                2'b10:   trk_count <= trk_count + 1'b1;
                2'b01:   trk_count <= trk_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Record the granted port index at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; trk_count alone
        // says which entries are live, so stale contents are never read.
        if (req_fire)
            trk_mem[trk_wr_ptr] <= winner;
    end

`ifdef PLAB5_MCORE_MEM_ARB_STATS_EN
    // Count cycles with pending requests but no grant, saturating at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (any_val && !req_fire && (stall_count != '1))
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_arbiter.sv
// Scoreboard bench for plab5_mcore_mem_arbiter (default parameters).
// Expected responses are queued in global issue order when the reference
// model decides a request fires; a separate monitor pops and compares them
// when a port accepts a response.
module tb_plab5_mcore_mem_arbiter;

    localparam int N    = 4;
    localparam int O    = 8;
    localparam int A    = 32;
    localparam int D    = 32;
    localparam int MAXO = 4;
    localparam int RQ   = 3 + O + A + $clog2(D / 8) + D;   // 77
    localparam int RS   = 3 + O + 2 + $clog2(D / 8) + D;   // 47

    logic            clk = 1'b0;
    logic            reset;
    logic [RQ*N-1:0] req_in_msg;
    logic [N-1:0]    req_in_val;
    logic [N-1:0]    req_in_rdy;
    logic [RS*N-1:0] resp_out_msg;
    logic [N-1:0]    resp_out_val;
    logic [N-1:0]    resp_out_rdy;
    logic [RQ-1:0]   mem_req_msg;
    logic            mem_req_val;
    logic            mem_req_rdy;
    logic [RS-1:0]   mem_resp_msg;
    logic            mem_resp_val;
    logic            mem_resp_rdy;
`ifdef PLAB5_MCORE_MEM_ARB_STATS_EN
    logic [31:0]     stall_count;
`endif

    plab5_mcore_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_in_msg   (req_in_msg),
        .req_in_val   (req_in_val),
        .req_in_rdy   (req_in_rdy),
        .resp_out_msg (resp_out_msg),
        .resp_out_val (resp_out_val),
        .resp_out_rdy (resp_out_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy)
`ifdef PLAB5_MCORE_MEM_ARB_STATS_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory behaviour: response = type, opaque, test=01, len, data^addr.
    function automatic logic [RS-1:0] mk_resp(input logic [RQ-1:0] r);
        return {r[76:74], r[73:66], 2'b01, r[33:32], r[31:0] ^ r[65:34]};
    endfunction

    function automatic logic [RQ-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[RQ-1:0];
    endfunction

    typedef struct packed { logic [31:0] port; logic [RS-1:0] msg; } exp_t;
    typedef struct packed { logic [31:0] due;  logic [RS-1:0] msg; } mem_t;

    exp_t exp_q[$];     // expected responses in global issue order
    mem_t mem_q[$];     // responses pending inside the memory model
    int   grant_log[$];
    int   grant_cyc[$];
    int   resp_log[$];
    int   resp_cyc[$];
    int   m_ptr = 0;

    // Requester state and stimulus knobs.
    logic [N-1:0]  hold_val = '0;
    logic [RQ-1:0] hold_msg [N];
    logic [N-1:0]  port_en = '0;
    int            new_pct = 0;
    int            mem_rdy_pct = 100;
    int            resp_rdy_pct = 100;
    logic          use_force = 1'b0;
    logic [N-1:0]  resp_force = '1;
    logic          mem_enable = 1'b1;
    logic          junk_force = 1'b0;
    logic          mem_real = 1'b0;
    int            lat_min = 1;
    int            lat_max = 1;

    task automatic inject(input int p);
        hold_msg[p] = rand_req();
        hold_val[p] = 1'b1;
    endtask

    // Drive all DUT inputs shortly after each rising edge.
    initial begin
        logic [63:0] j;
        req_in_val   = '0;
        req_in_msg   = '0;
        resp_out_rdy = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        for (int p = 0; p < N; p++) hold_msg[p] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (!hold_val[p] && port_en[p] && reset && ($urandom_range(0, 99) < new_pct)) begin
                    hold_msg[p] = rand_req();
                    hold_val[p] = 1'b1;
                end
                req_in_val[p]            = hold_val[p];
                req_in_msg[p*RQ +: RQ]   = hold_msg[p];
                resp_out_rdy[p]          = use_force ? resp_force[p]
                                                     : ($urandom_range(0, 99) < resp_rdy_pct);
            end
            mem_req_rdy = ($urandom_range(0, 99) < mem_rdy_pct);
            if (mem_q.size() > 0) begin
                mem_real     = 1'b1;
                mem_resp_val = mem_enable && (cyc >= int'(mem_q[0].due));
                mem_resp_msg = mem_q[0].msg;
            end else begin
                j            = {$urandom(), $urandom()};
                mem_real     = 1'b0;
                mem_resp_val = junk_force || ($urandom_range(0, 3) == 0);
                mem_resp_msg = j[RS-1:0];
            end
        end
    end

    // Reference model: checks combinational outputs each cycle, then applies fires.
    initial begin
        int            win;
        int            h;
        logic          full;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rval;
        logic          exp_mrdy;
        exp_t          e;
        mem_t          m;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                m_ptr = 0;
                exp_q.delete();
                mem_q.delete();
                check("rst_mem_resp_rdy", mem_resp_rdy, 0);
                check("rst_resp_out_val", resp_out_val, 0);
                check("rst_mem_req_val", mem_req_val, |req_in_val);
            end else begin
                win = -1;
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_in_val[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                full = (exp_q.size() >= MAXO);
                check("mem_req_val", mem_req_val, (win >= 0) && !full);
                exp_rdy = '0;
                if (win >= 0 && !full && mem_req_rdy) exp_rdy[win] = 1'b1;
                check("req_in_rdy", req_in_rdy, exp_rdy);
                if (win >= 0 && !full)
                    check("mem_req_msg", mem_req_msg, req_in_msg[win*RQ +: RQ]);

                exp_rval = '0;
                exp_mrdy = 1'b0;
                if (exp_q.size() > 0) begin
                    h = int'(exp_q[0].port);
                    exp_rval[h] = mem_resp_val;
                    exp_mrdy    = resp_out_rdy[h];
                    if (mem_resp_val)
                        check("resp_out_msg", resp_out_msg[h*RS +: RS], mem_resp_msg);
                end
                check("resp_out_val", resp_out_val, exp_rval);
                check("mem_resp_rdy", mem_resp_rdy, exp_mrdy);

                // Memory side behaviour.
                if (mem_resp_val && mem_resp_rdy && mem_real && mem_q.size() > 0)
                    m = mem_q.pop_front();
                if (mem_req_val && mem_req_rdy) begin
                    m.due = 32'(cyc + int'($urandom_range(lat_min, lat_max)));
                    m.msg = mk_resp(mem_req_msg);
                    mem_q.push_back(m);
                end
                // Requesters drop val after their own handshake.
                for (int p = 0; p < N; p++)
                    if (hold_val[p] && req_in_val[p] && req_in_rdy[p]) hold_val[p] = 1'b0;
                // Model-side fire: queue the expected response for this requester.
                if (win >= 0 && !full && mem_req_rdy) begin
                    e.port = 32'(win);
                    e.msg  = mk_resp(req_in_msg[win*RQ +: RQ]);
                    exp_q.push_back(e);
                    grant_log.push_back(win);
                    grant_cyc.push_back(cyc);
                    m_ptr = (win + 1) % N;
                end
            end
        end
    end

    // Monitor: whenever a port accepts a response, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1) begin
                for (int p = 0; p < N; p++) begin
                    if (resp_out_val[p] && resp_out_rdy[p]) begin
                        if (exp_q.size() == 0) begin
                            check("resp_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("resp_port", p, e.port);
                            check("resp_msg", resp_out_msg[p*RS +: RS], e.msg);
                            resp_log.push_back(p);
                            resp_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        hold_val = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int c = 0;
        while (grant_log.size() < n && c < 300) begin
            @(posedge clk);
            c++;
        end
        check(name, grant_log.size() >= n, 1);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (!(hold_val == '0 && exp_q.size() == 0 && mem_q.size() == 0) && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check(name, (hold_val == '0 && exp_q.size() == 0 && mem_q.size() == 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req_val", mem_req_val, 0);
        check("reset_mem_resp_rdy", mem_resp_rdy, 0);
        check("reset_resp_out_val", resp_out_val, 0);
        check("reset_req_in_rdy", req_in_rdy, 0);
        @(posedge clk);
        #3 reset = 1'b1;

        // All four ports continuously valid: strict rotation from port 0.
        @(posedge clk);
        grant_log.delete(); grant_cyc.delete(); resp_log.delete(); resp_cyc.delete();
        port_en = '1;
        new_pct = 100;
        wait_grants(6, "rr4_timeout");
        new_pct = 0;
        for (int i = 0; i < 6; i++)
            check($sformatf("rr4_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, i % 4);
        wait_idle("rr4_drain");
        for (int i = 0; i < 6; i++)
            check($sformatf("rr4_resp_port%0d", i), (resp_log.size() > i) ? resp_log[i] : -1, i % 4);

        // Only ports 1 and 3 valid with pointer at 2: 3, 1, 3.
        port_en = '0;
        grant_log.delete(); grant_cyc.delete();
        inject(1);
        wait_grants(1, "rr2_setup_timeout");
        grant_log.delete(); grant_cyc.delete();
        port_en = 4'b1010;
        new_pct = 100;
        wait_grants(3, "rr2_timeout");
        new_pct = 0;
        port_en = '0;
        check("rr2_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
        check("rr2_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
        check("rr2_grant2", (grant_log.size() > 2) ? grant_log[2] : -1, 3);
        wait_idle("rr2_drain");

        // Tracker full: four fire, the fifth waits for the first pop.
        grant_log.delete(); grant_cyc.delete(); resp_log.delete(); resp_cyc.delete();
        mem_enable = 1'b0;
        for (int p = 0; p < N; p++) inject(p);
        wait_grants(4, "full_fill_timeout");
        inject(0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_mem_req_val", mem_req_val, 0);
        check("full_req_in_rdy", req_in_rdy, 0);
        check("full_grants", grant_log.size(), 4);
        @(posedge clk);
        mem_enable = 1'b1;
        wait_grants(5, "full_resume_timeout");
        check("full_resume_gap",
              (grant_cyc.size() > 4 && resp_cyc.size() > 0) ? grant_cyc[4] - resp_cyc[0] : -1, 1);
        wait_idle("full_drain");

        // Head port 2 not ready: response held until its rdy rises.
        grant_log.delete(); grant_cyc.delete(); resp_log.delete(); resp_cyc.delete();
        mem_enable = 1'b0;
        inject(2);
        wait_grants(1, "hold_setup_timeout");
        use_force  = 1'b1;
        resp_force = 4'b1011;
        mem_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_mem_resp_rdy", mem_resp_rdy, 0);
        check("hold_resp_out_val", resp_out_val, 4'b0100);
        check("hold_no_delivery", resp_log.size(), 0);
        @(posedge clk);
        resp_force = 4'b1111;
        wait_idle("hold_drain");
        check("hold_deliver_port", (resp_log.size() == 1) ? resp_log[0] : -1, 2);
        use_force = 1'b0;

        // Reset with three outstanding: entries dropped, pointer back to 0.
        grant_log.delete(); grant_cyc.delete();
        mem_enable = 1'b0;
        inject(0); inject(1); inject(2);
        wait_grants(3, "rst_setup_timeout");
        #3 reset = 1'b0;
        hold_val = '0;
        @(negedge clk);
        check("rst_mid_mem_resp_rdy", mem_resp_rdy, 0);
        check("rst_mid_resp_out_val", resp_out_val, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        mem_enable = 1'b1;
        junk_force = 1'b1;
        @(negedge clk);
        check("post_rst_mem_resp_rdy", mem_resp_rdy, 0);
        @(negedge clk);
        check("post_rst_mem_resp_rdy2", mem_resp_rdy, 0);
        check("post_rst_resp_out_val", resp_out_val, 0);
        @(posedge clk);
        junk_force = 1'b0;
        grant_log.delete(); grant_cyc.delete();
        inject(0); inject(3);
        wait_grants(1, "post_rst_timeout");
        check("post_rst_winner", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        wait_idle("post_rst_drain");

        // Randomized traffic with backpressure on every interface.
        port_en      = '1;
        new_pct      = 40;
        mem_rdy_pct  = 70;
        resp_rdy_pct = 70;
        lat_min      = 1;
        lat_max      = 4;
        repeat (2000) @(posedge clk);
        new_pct      = 0;
        mem_rdy_pct  = 100;
        resp_rdy_pct = 100;
        wait_idle("random_drain");
        port_en = '0;

`ifdef PLAB5_MCORE_MEM_ARB_STATS_EN
        // Ten stalled cycles with port 0 valid and memory not ready.
        do_reset();
        mem_rdy_pct = 0;
        @(posedge clk);
        inject(0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_count", stall_count, 10);
        mem_rdy_pct = 100;
        wait_idle("stall_drain");
`else
        do_reset();
        wait_idle("final_idle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plab5_mcore_mem_arbiter.md
PLAB5_MCORE_MEM_ARBITER -- requirements
Module: plab5_mcore_MemArbiter

Interface
REQ-001 SHALL have parameter p_num_ports, default 4, number of requester ports sharing one memory port.
REQ-002 SHALL have parameter p_mem_opaque_nbits, default 8, memory message opaque field width.
REQ-003 SHALL have parameter p_mem_addr_nbits, default 32, memory address width.
REQ-004 SHALL have parameter p_mem_data_nbits, default 32, memory data width.
REQ-005 SHALL have parameter p_max_outstanding, default 4 (power of two, >= 2), response-routing tracker depth.
REQ-006 SHALL define rq = VC_MEM_REQ_MSG_NBITS(o,a,d) and rs = VC_MEM_RESP_MSG_NBITS(o,d).
REQ-007 Ports: clk  in  1  single clock, all state on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 req_in_msg  in  rq*p_num_ports  requester requests, port i in field i.
REQ-010 req_in_val  in  p_num_ports;  req_in_rdy  out  p_num_ports.
REQ-011 resp_out_msg  out  rs*p_num_ports;  resp_out_val  out  p_num_ports;  resp_out_rdy  in  p_num_ports.
REQ-012 mem_req_msg  out  rq;  mem_req_val  out  1;  mem_req_rdy  in  1  shared memory request port.
REQ-013 mem_resp_msg  in  rs;  mem_resp_val  in  1;  mem_resp_rdy  out  1  shared memory response port.

Function
REQ-014 All handshakes SHALL be val/rdy; a transfer fires when val and rdy are both high at a rising clk edge.
REQ-015 Arbitration SHALL be round-robin: winner = first asserted req_in_val at or after priority pointer ptr, wrapping p_num_ports-1 -> 0.
REQ-016 mem_req_val SHALL equal (any req_in_val) AND NOT tracker_full; mem_req_msg SHALL equal the winner's req_in_msg, combinationally (zero latency).
REQ-017 req_in_rdy[i] SHALL be high only for the winner, and only when mem_req_rdy is high and the tracker is not full; all others low.
REQ-018 On request fire, ptr SHALL update to (winner+1) mod p_num_ports; otherwise ptr holds.
REQ-019 On request fire, the winner index SHALL be pushed into an in-order tracker FIFO of depth p_max_outstanding.
REQ-020 Tracker full SHALL block all grants; no push-bypass when full, even if a pop occurs the same cycle.
REQ-021 Tracker empty: mem_resp_rdy SHALL be 0 and all resp_out_val SHALL be 0; mem_resp_val is ignored.
REQ-022 Tracker non-empty with head h: resp_out_val[h] = mem_resp_val, resp_out_msg field h = mem_resp_msg, mem_resp_rdy = resp_out_rdy[h]; all other resp_out_val low.
REQ-023 Response fire SHALL pop the tracker; simultaneous push and pop on a non-empty tracker SHALL leave occupancy unchanged.
REQ-024 Occupancy counter and FIFO read/write pointers SHALL wrap modulo p_max_outstanding; counter width clog2(p_max_outstanding)+1.
REQ-025 resp_out_msg fields of non-selected ports SHALL be driven with mem_resp_msg (don't-care, no X).
REQ-026 Message contents, including opaque fields, SHALL pass unmodified in both directions.

Reset
REQ-027 While reset is low: ptr = 0, tracker empty (count 0, pointers 0), stall counter 0; hence mem_req_val = 0 only if no req_in_val, mem_resp_rdy = 0, resp_out_val = 0.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding tracker entries immediately; responses arriving afterward are not accepted until a new request fires.

Configuration
REQ-029 Macro PLAB5_MCORE_MEM_ARB_STATS_EN defined: output port stall_count (out, 32) SHALL count cycles where any req_in_val is high and no request fires, saturating at 32'hFFFFFFFF, reset to 0.
REQ-030 Macro undefined: stall_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 All four ports valid continuously, mem_req_rdy=1, mem_resp returned each cycle -> grant order 0,1,2,3,0,1 and each response delivered to the issuing port.
REQ-032 Only ports 1 and 3 valid, ptr=2 -> port 3 granted first, then 1, then 3.
REQ-033 mem_resp_val held 0, ports issue 5 requests, p_max_outstanding=4 -> 4 fire, mem_req_val drops, 5th fires the cycle after first response pop.
REQ-034 Tracker head=2, resp_out_rdy=4'b1011 -> mem_resp_rdy=0, response held; set bit 2 -> fires to port 2 only.
REQ-035 Reset pulsed low with 3 outstanding -> mem_resp_rdy=0 next cycle, ptr=0, port 0 wins next contested grant.
REQ-036 STATS_EN defined, mem_req_rdy=0 for 10 cycles with port 0 valid -> stall_count=10; undefined -> builds without port.
